pipeline_hazard_ctrl: RTL

Hazard and stall sequencer for the 5-stage MIPS pipeline. It watches the instruction in ID and the instruction in EXE, and drives PC write-enable, IF/ID write-enable and flush, and the ID/EXE `flush` input. It also runs a multi-cycle stall FSM for the multiply/divide unit (MDU). It sits beside the ID stage, between the decoder/register file and the ID/EXE pipeline register.

---
 rtl/pipeline_hazard_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use, branch-flush and MDU stall sequencer
// for the 5-stage MIPS pipeline; sits beside ID, ahead of ID/EXE.
//
// Parameter:
//   MDU_LATENCY   total stall cycles of a mult/div incl. start (2..15)
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   id_rs, id_rt      source fields of the ID instruction
//   id_uses_rt        ID instruction reads rt
//   exe_mem_read      EXE instruction is a load
//   exe_rt            load destination in EXE
//   id_branch_taken   branch/jump resolved taken in ID
//   id_is_mdu         ID instruction is mult/div
//   pc_write          PC update enable
//   if_id_write       IF/ID update enable
//   if_id_flush       zero IF/ID on the next edge
//   id_exe_flush      bubble into ID/EXE
//   mdu_start         one-cycle MDU start pulse
//   mdu_busy          registered, high while waiting on the MDU
// Optional (define HAZARD_STATS_EN):
//   stall_cnt, flush_cnt  saturating 16-bit event counters
module pipeline_hazard_ctrl #(
    parameter int MDU_LATENCY = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic       exe_mem_read,
    input  logic [4:0] exe_rt,
    input  logic       id_branch_taken,
    input  logic       id_is_mdu,
    output logic       pc_write,
    output logic       if_id_write,
    output logic       if_id_flush,
    output logic       id_exe_flush,
    output logic       mdu_start,
    output logic       mdu_busy
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
`endif
);

    typedef enum logic {
        RUN      = 1'b0,
        MDU_WAIT = 1'b1
    } state_t;

    // cnt holds the number of stall cycles still owed in MDU_WAIT; the
    // cycle in which it reads zero is the release cycle. Loading L-1
    // gives start + (L-1) waits = L stall cycles in total.
    localparam logic [3:0] CNT_LOAD = 4'(MDU_LATENCY - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       lu;

    // Register 0 is hard-wired, so a load into it never creates a hazard.
    assign lu = exe_mem_read && (exe_rt != 5'd0) &&
                ((exe_rt == id_rs) || (id_uses_rt && (exe_rt == id_rt)));

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_exe_flush = 1'b0;
        mdu_start    = 1'b0;
        if (rst) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_exe_flush = 1'b1;
        end else begin
            unique case (state)
                RUN: begin
                    if (lu) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_exe_flush = 1'b1;
                    end else if (id_is_mdu) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_exe_flush = 1'b1;
                        mdu_start    = 1'b1;
                    end else if (id_branch_taken) begin
                        if_id_flush  = 1'b1;
                    end
                end
                MDU_WAIT: begin
                    // Release cycle (cnt == 0) ignores all ID/EXE inputs.
                    if (cnt != 4'd0) begin
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        id_exe_flush = 1'b1;
                    end
                end
                default: begin
                    pc_write     = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN;
            cnt      <= 4'd0;
            mdu_busy <= 1'b0;
        end else begin
            unique case (state)
                RUN: begin
                    if (!lu && id_is_mdu) begin
                        state    <= MDU_WAIT;
                        cnt      <= CNT_LOAD;
                        mdu_busy <= 1'b1;
                    end
                end
                MDU_WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state    <= RUN;
                        mdu_busy <= 1'b0;
                    end
                end
                default: begin
                    state    <= RUN;
                    cnt      <= 4'd0;
                    mdu_busy <= 1'b0;
                end
            endcase
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 16'd0;
            flush_cnt <= 16'd0;
        end else begin
            if (!pc_write && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
            if (if_id_flush && (flush_cnt != 16'hFFFF)) begin
                flush_cnt <= flush_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
